// File: rtl/demux_stream_sched.sv
// demux_stream_sched
//   Scheduler for a 1-to-4 stream demux. Each beat accepted on the single
//   valid/ready input is steered to one output channel. The channel comes
//   from a round-robin scan over the enabled channels (mode=0) or from the
//   per-beat destination field (mode=1). A single registered output stage
//   holds the beat until the selected channel accepts it.
//
// Ports
//   clk, rst    clock (rising edge) and synchronous active-high reset
//   mode        0 = round-robin, 1 = direct (in_dest selects the channel)
//   chan_en     per-channel enable mask
//   in_valid / in_ready / in_data / in_dest   input stream
//   out_valid   one-hot valid, bit i = channel i
//   out_ready   per-channel ready; only the bit of the held channel is used
//   out_data    data shared by all channels, qualified by out_valid
//   out_sel     channel index of the held beat
//   drop        one-cycle pulse when a direct-mode beat to a disabled
//               channel is discarded
//
// Optional build macro DEMUX_SCHED_CNT_EN adds per-channel 16-bit saturating
// transfer counters with ports cnt_sel (read select), cnt_clr (clear all) and
// cnt_val (registered count of channel cnt_sel).

module demux_stream_sched #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              drop
`ifdef DEMUX_SCHED_CNT_EN
    ,
    input  logic [1:0]        cnt_sel,
    input  logic              cnt_clr,
    output logic [15:0]       cnt_val
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        rr_q, rr_d;
    logic              drop_q, drop_d;

    logic       xfer_out;
    logic       slot_free;
    logic       target_ok;
    logic       accept;
    logic       load;
    logic       discard;
    logic [1:0] grant;
    logic [1:0] scan_idx;
    logic       found;

    // Round-robin scan starting at rr_q; 2-bit index wraps modulo 4.
    always_comb begin
        grant    = rr_q;
        scan_idx = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            scan_idx = rr_q + 2'(k);
            if (!found && chan_en[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
    end

    // Output slot can take a new beat when empty or when the held beat
    // leaves this cycle, giving back-to-back transfers with no bubble.
    assign xfer_out  = (state_q == HOLD) && out_ready[sel_q];
    assign slot_free = (state_q == IDLE) || out_ready[sel_q];
    assign target_ok = mode ? 1'b1 : (|chan_en);
    assign in_ready  = slot_free && target_ok;
    assign accept    = in_valid && in_ready;
    assign load      = accept && (!mode || chan_en[in_dest]);
    assign discard   = accept && mode && !chan_en[in_dest];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        rr_d    = rr_q;
        drop_d  = discard;
        if (load) begin
            state_d = HOLD;
            data_d  = in_data;
            if (mode) begin
                sel_d = in_dest;
            end else begin
                sel_d = grant;
                rr_d  = grant + 2'd1;
            end
        end else if (xfer_out) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            rr_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = (state_q == HOLD) ? (NUM_CH'(1) << sel_q) : '0;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign drop      = drop_q;

`ifdef DEMUX_SCHED_CNT_EN
    logic [15:0] cnt_q [NUM_CH];
    logic [15:0] cnt_val_q;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (xfer_out && (cnt_q[sel_q] != '1)) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_val_q <= '0;
        end else begin
            cnt_val_q <= cnt_q[cnt_sel];
        end
    end

    assign cnt_val = cnt_val_q;
`endif

endmodule
